// File: rtl/onehot_index_encoder.sv
// onehot_index_encoder
//   Captures a 2**N-bit multi-hot vector and emits the N-bit index of every
//   set bit, lowest index first, one index per out_valid/out_ready handshake.
//   A one-cycle done pulse marks the end of each accepted vector.
//
// Handshake: an index transfers on a rising edge where out_valid && out_ready.
//   Once out_valid is high it stays high, with out_idx/out_count stable,
//   until that transfer happens. load is a request that is accepted only
//   while busy=0. While busy=1 it is ignored and in is not sampled.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   load       capture request (accepted only while busy=0)
//   in         multi-hot vector to encode (2**N bits)
//   busy       high while indices are pending (state EMIT)
//   out_valid  out_idx holds a valid index (state EMIT)
//   out_ready  consumer accepts out_idx when out_valid=1
//   out_idx    index of the lowest pending set bit (0 when none pending)
//   out_count  indices emitted since the last accepted load (N+1 bits)
//   zero       last accepted load carried an all-zero vector
//   done       one-cycle pulse after a vector is fully processed
//   dbg_state  current FSM state (0=IDLE, 1=EMIT) for checkers
module onehot_index_encoder #(
  parameter int N = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [2**N-1:0] in,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_idx,
  output logic [N:0]      out_count,
  output logic            zero,
  output logic            done,
  output logic            dbg_state
);

  localparam int W = 2**N;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t         state_q;
  logic [W-1:0]   pending_q;
  logic [N:0]     count_q;
  logic           zero_q;
  logic           done_q;

  logic [W-1:0]   pending_d;
  logic [N-1:0]   lowest_idx;
  logic           handshake;

  // Clearing the lowest set bit: x & (x - 1).
  assign pending_d = pending_q & (pending_q - W'(1));

  // Priority scan from the top down, so the lowest set bit wins.
  always_comb begin
    lowest_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        lowest_idx = N'(i);
      end
    end
  end

  assign handshake = (state_q == EMIT) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            pending_q <= in;
            count_q   <= '0;
            if (in != '0) begin
              zero_q  <= 1'b0;
              state_q <= EMIT;
            end else begin
              // Empty vector completes immediately without emitting.
              zero_q  <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (handshake) begin
            pending_q <= pending_d;
            count_q   <= count_q + (N+1)'(1);
            if (pending_d == '0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q == EMIT);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = lowest_idx;
  assign out_count = count_q;
  assign zero      = zero_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/onehot_index_encoder.md
Name: onehot_index_encoder

Overview:
- Sequential inverse of the team's N-to-2^N decoder.
- Captures a 2^N-bit multi-hot vector and emits the N-bit index of every set bit, lowest index first, one per valid/ready handshake.
- Sits between status/request vectors (register-write enables, interrupt lines) and logic that consumes binary indices.
- Signals completion with a one-cycle done pulse, so a bench can drive the decoder with its outputs and check the round trip.

Parameters:
- N, 2, index width; input vector width is 2**N.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load  input  1  request to capture in; accepted only when busy=0
- in  input  2**N  multi-hot vector to encode
- busy  output  1  high from the cycle after an accepted non-zero load until the final handshake's edge
- out_valid  output  1  out_idx holds a valid index
- out_ready  input  1  consumer accepts out_idx when out_valid=1
- out_idx  output  N  index of the lowest set bit still pending
- out_count  output  N+1  number of indices emitted since the last accepted load
- zero  output  1  registered; last accepted load carried an all-zero vector
- done  output  1  one-cycle pulse when a vector is fully processed

Behaviour:
- Reset, sampled at a rising edge of clk while reset=1:
  - state=IDLE, pending=0, out_count=0, zero=0, done=0.
  - Therefore busy=0, out_valid=0 and out_idx=0.
  - reset overrides every other input, including a mid-vector reset: the pending bits are discarded and no done pulse is generated.
- States are IDLE and EMIT.
  - busy=1 and out_valid=1 exactly when state=EMIT.
  - out_idx is combinational from pending: the index of its lowest set bit, or 0 when pending=0.
- IDLE with load=1 at edge k:
  - pending<=in and out_count<=0.
  - If in!=0: zero<=0 and state<=EMIT. out_valid=1 from cycle k+1, giving one cycle of load-to-valid latency.
  - If in==0: zero<=1, done<=1 for cycle k+1, state stays IDLE.
- IDLE with load=0: hold all state. done<=0.
- EMIT, when out_valid&&out_ready at an edge:
  - Clear the lowest set bit of pending.
  - out_count<=out_count+1.
  - If that was the last set bit: state<=IDLE and done=1 for the next cycle.
  - Otherwise stay in EMIT. The next index is valid in the following cycle with no bubble.
- EMIT with out_ready=0: out_idx, out_count and pending hold stable. out_valid stays high and must not drop without a handshake.
- load while busy=1 is ignored completely; in is not sampled.
- load in the cycle where done=1 (state already IDLE) is accepted normally. Back-to-back vectors are allowed.
- done is high for exactly one cycle per accepted load, and never during reset.
- out_count after completion equals the popcount of the loaded vector; maximum 2**N, hence N+1 bits.
- The output order is strictly ascending index. There is no wrap-around: bits already cleared are never revisited.

Test Plan:
- Reset, then load in=4'b1010 with out_ready=1.
  - Cycle 1: out_idx=1.
  - Cycle 2: out_idx=3.
  - Cycle 3: done=1, busy=0, out_count=2, zero=0.
- Load in=4'b1111 with out_ready=1.
  - Indices 0,1,2,3 appear on four consecutive cycles.
  - done follows in the next cycle, and out_count=4.
- Load in=4'b0000.
  - Next cycle: done=1, zero=1, out_valid never asserts, out_count=0.
- Load in=4'b0110 with out_ready=0 for 3 cycles.
  - out_idx stays 1 and out_count stays 0 throughout.
  - Raise out_ready: 1, then 2, then done.
- Load 4'b1001, then assert load with in=4'b0100 while busy.
  - The second vector is ignored: output is 0, 3, then done.
  - Assert load with in=4'b0100 again in the done cycle: out_idx=2 appears next cycle.
- Load 4'b1100, then assert reset after the first handshake.
  - Next cycle: busy=0, out_valid=0, out_count=0, no done pulse.
  - Round trip: feed each emitted out_idx into decoder #2. The OR of the decoder outputs must equal the loaded vector.
